// File: rtl/control_abc.sv
// Sequencing controller for the three-memory SUBLEQ core: six-state instruction
// loop plus idle/start, single-step, halt control and retire/cycle counters.
module control_abc #(
    parameter int unsigned COUNT_W   = 32,
    parameter int unsigned MAX_INSTR = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_step_mode,
    input  logic               i_halt_req,
    input  logic               i_zero,
    input  logic               i_negative,
    output logic [2:0]         o_state,
    output logic               o_read_en_abc,
    output logic               o_abc_ld,
    output logic               o_read_en_ab,
    output logic               o_mem_ab_ld,
    output logic               o_result_ld,
    output logic               o_write_en_b,
    output logic               o_pc_ld,
    output logic               o_branch_taken,
    output logic               o_busy,
    output logic               o_halted,
    output logic [COUNT_W-1:0] o_instr_count,
    output logic [COUNT_W-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        S_FETCH_ABC   = 3'd0,
        S_LOAD_ABC    = 3'd1,
        S_FETCH_MEMAB = 3'd2,
        S_LOAD_MEMAB  = 3'd3,
        S_EXECUTE     = 3'd4,
        S_WRITEBACK   = 3'd5,
        S_HALT        = 3'd6,
        S_IDLE        = 3'd7
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [COUNT_W:0]   BUDGET  = (COUNT_W+1)'(MAX_INSTR);

    state_t               r_state;
    state_t               w_next_state;
    logic [6:0]           r_strobes;
    logic [6:0]           w_strobes;
    logic                 r_busy;
    logic                 r_halted;
    logic                 r_halt_pending;
    logic                 r_branch_taken;
    logic [COUNT_W-1:0]   r_instr_count;
    logic [COUNT_W-1:0]   r_cycle_count;
    logic                 w_busy;
    logic                 w_next_busy;
    logic                 w_budget_hit;

    assign w_busy       = (r_state != S_HALT) && (r_state != S_IDLE);
    assign w_next_busy  = (w_next_state != S_HALT) && (w_next_state != S_IDLE);
    assign w_budget_hit = (MAX_INSTR != 0) &&
                          (({1'b0, r_instr_count} + (COUNT_W+1)'(1)) == BUDGET);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; halt requests never abandon an in-flight instruction
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_halt_req) begin
                    w_next_state = S_HALT;
                end else if (i_start) begin
                    w_next_state = S_FETCH_ABC;
                end
            end
            S_FETCH_ABC:   w_next_state = S_LOAD_ABC;
            S_LOAD_ABC:    w_next_state = S_FETCH_MEMAB;
            S_FETCH_MEMAB: w_next_state = S_LOAD_MEMAB;
            S_LOAD_MEMAB:  w_next_state = S_EXECUTE;
            S_EXECUTE:     w_next_state = S_WRITEBACK;
            S_WRITEBACK: begin
                if (r_halt_pending || i_halt_req || w_budget_hit) begin
                    w_next_state = S_HALT;
                end else if (i_step_mode) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_FETCH_ABC;
                end
            end
            S_HALT:        w_next_state = S_HALT;
        endcase
    end

    // Strobes decoded from the next state so the registered copy tracks r_state
    always_comb begin
        w_strobes = '0;
        case (w_next_state)
            S_FETCH_ABC:   w_strobes[6]   = 1'b1;
            S_LOAD_ABC:    w_strobes[5]   = 1'b1;
            S_FETCH_MEMAB: w_strobes[4]   = 1'b1;
            S_LOAD_MEMAB:  w_strobes[3]   = 1'b1;
            S_EXECUTE:     w_strobes[2]   = 1'b1;
            S_WRITEBACK:   w_strobes[1:0] = 2'b11;
            default:       w_strobes      = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_strobes      <= '0;
            r_busy         <= 1'b0;
            r_halted       <= 1'b0;
            r_halt_pending <= 1'b0;
            r_branch_taken <= 1'b0;
            r_instr_count  <= '0;
            r_cycle_count  <= '0;
        end else begin
            r_strobes <= w_strobes;
            r_busy    <= w_next_busy;
            r_halted  <= (w_next_state == S_HALT);
            if (w_next_state == S_HALT) begin
                r_halt_pending <= 1'b0;
            end else if (w_busy && i_halt_req) begin
                r_halt_pending <= 1'b1;
            end
            if (r_state == S_EXECUTE) begin
                r_branch_taken <= i_zero | i_negative;
            end
            // Counters saturate rather than wrap
            if (w_busy && (r_cycle_count != CNT_MAX)) begin
                r_cycle_count <= r_cycle_count + COUNT_W'(1);
            end
            if ((r_state == S_WRITEBACK) && (r_instr_count != CNT_MAX)) begin
                r_instr_count <= r_instr_count + COUNT_W'(1);
            end
        end
    end

    assign o_state        = 3'(r_state);
    assign o_read_en_abc  = r_strobes[6];
    assign o_abc_ld       = r_strobes[5];
    assign o_read_en_ab   = r_strobes[4];
    assign o_mem_ab_ld    = r_strobes[3];
    assign o_result_ld    = r_strobes[2];
    assign o_write_en_b   = r_strobes[1];
    assign o_pc_ld        = r_strobes[0];
    assign o_branch_taken = r_branch_taken;
    assign o_busy         = r_busy;
    assign o_halted       = r_halted;
    assign o_instr_count  = r_instr_count;
    assign o_cycle_count  = r_cycle_count;

endmodule

// File: doc/control_abc.md
# control_abc

Sequencing controller for the three-memory SUBLEQ core. It sits directly upstream of the ABC datapath and drives that datapath's load, read, write and PC strobes and its 3-bit `state` bus. It also consumes the ALU `zero`/`negative` flags. Beyond the base six-state instruction loop, it adds start/idle handling, single-step mode, halt control, and instruction and cycle counters for the simulation harness.

## Interface
Parameters:
- `COUNT_W`, 32, width of `instr_count` and `cycle_count`.
- `MAX_INSTR`, 0, instruction budget. The block halts after this many retired instructions. 0 disables the budget.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch request, honoured only in IDLE.
- `step_mode`  in  1  1 = return to IDLE after each instruction.
- `halt_req`  in  1  external halt request; may be a single-cycle pulse.
- `zero`  in  1  ALU zero flag from the datapath.
- `negative`  in  1  ALU negative flag from the datapath.
- `state`  out  3  current state code, wired to the datapath.
- `read_en_abc`, `abc_ld`, `read_en_ab`, `mem_ab_ld`, `result_ld`, `write_en_b`, `pc_ld`  out  1 each  datapath strobes.
- `branch_taken`  out  1  registered; equals `zero|negative` sampled in EXECUTE.
- `busy`  out  1  high in states 0–5.
- `halted`  out  1  high in HALT.
- `instr_count`  out  COUNT_W  number of retired instructions.
- `cycle_count`  out  COUNT_W  number of busy cycles.

## Operation
State codes:
- FETCH_ABC=0, LOAD_ABC=1, FETCH_MEM_AB=2, LOAD_MEM_AB=3, EXECUTE=4, WRITEBACK_UPDATE_PC=5, HALT=6, IDLE=7.

Strobes are Moore outputs, decoded from the state register. Exactly one strobe set is active per state:
- 0: `read_en_abc`.
- 1: `abc_ld`.
- 2: `read_en_ab`.
- 3: `mem_ab_ld`.
- 4: `result_ld`.
- 5: `write_en_b` and `pc_ld`.
- 6, 7: none.

Transitions:
- 0→1→2→3→4→5, unconditional, one cycle each.
- IDLE: `halt_req`→HALT. Otherwise `start`→FETCH_ABC. Otherwise stay. `halt_req` has priority over `start`.
- 5: the instruction retires. Next state is chosen in this priority order:
  - HALT if `halt_pending` is set, `halt_req` is high this cycle, or the budget is hit.
  - IDLE if `step_mode` is 1.
  - FETCH_ABC otherwise.
- HALT is sticky until `rst`. `start` is ignored in HALT.

Halt pending:
- `halt_pending` sets on `halt_req` in any of states 0–5.
- It clears on entering HALT and on `rst`.
- An in-flight instruction always completes through WRITEBACK_UPDATE_PC. It is never abandoned.

Budget:
- The budget is hit in state 5 when `MAX_INSTR`≠0 and `instr_count+1 == MAX_INSTR`.

Branch flag:
- `branch_taken` loads `zero|negative` in EXECUTE and holds until the next EXECUTE.
- The datapath PC unit uses its own `pc_ld`/`state`. `branch_taken` is for observation and checking only.

Counters:
- `instr_count` increments at the end of each state-5 cycle.
- `cycle_count` increments every cycle in states 0–5.
- Both saturate at all-ones and do not wrap.

## Timing
- Reset values:
  - `state`=7 (IDLE).
  - All strobes 0.
  - `branch_taken`=0, `busy`=0, `halted`=0, `halt_pending`=0.
  - Both counters 0.
- `rst` overrides everything, including mid-instruction. On the next edge the block is in IDLE with all strobes low.
- Launch: with `start` high at edge N in IDLE, FETCH_ABC is active in cycle N+1.
- Each instruction takes exactly 6 cycles. In run mode there are no bubbles between instructions.
- In step mode, each instruction takes 6 busy cycles plus at least 1 IDLE cycle.
- `halted` rises in the cycle after the last state 5.
- `instr_count` reflects the retired instruction in the cycle after state 5.

## Test plan
- Reset, then `start` pulse (`step_mode`=0, `MAX_INSTR`=0) → `state` sequence 7,0,1,2,3,4,5,0,… with the single correct strobe per cycle. `instr_count`=2 after 12 busy cycles; `cycle_count`=12.
- Flags at EXECUTE: (`zero`,`negative`) = (1,0), then (0,0), then (0,1) in consecutive instructions → `branch_taken` = 1, 0, 1, each visible from the cycle after state 4.
- `step_mode`=1, three `start` pulses spaced 10 cycles apart → three 6-cycle bursts, each returning to IDLE. `instr_count`=3; `cycle_count`=18.
- `halt_req` one-cycle pulse during state 2 → states 3,4,5 still execute with `write_en_b`/`pc_ld` asserted. Then `state`=6 with `halted`=1, and later `start` pulses have no effect.
- `MAX_INSTR`=3, run mode → HALT after exactly 18 busy cycles with `instr_count`=3. `halt_req` and `start` asserted together in IDLE → HALT with no fetch.
- `rst` asserted during state 4 → next cycle `state`=7, all strobes 0, counters 0. A subsequent `start` runs a normal instruction.
